// File: rtl/iter_exec_unit.sv
// Multi-cycle execute stage: one-cycle ALU/lui results, iterative one-bit-per-cycle shifts
// behind a start/busy/done handshake.
module iter_exec_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [3:0]        ALU_operation_i,
  input  logic [1:0]        FURslt_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [4:0]        shamt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              overflow_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic        [3:0]        op_q;
  logic        [1:0]        fur_q;
  logic signed [DATA_W-1:0] a_q;
  logic signed [DATA_W-1:0] b_q;
  logic        [DATA_W-1:0] sh_q;
  logic        [4:0]        cnt_q;
  logic        [4:0]        cnt_load;
  logic                     accept;
  logic        [DATA_W-1:0] res_d;
  logic                     ovf_d;

  function automatic logic [DATA_W-1:0] alu_result(input logic [3:0] op,
                                                   input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
    case (op)
      4'b0000:          return a & b;
      4'b0001:          return a | b;
      4'b0010:          return a + b;
      4'b0110:          return a - b;
      4'b1100:          return ~(a | b);
      4'b0111, 4'b1000: return {{(DATA_W-1){1'b0}}, (a < b)};
      default:          return '0;
    endcase
  endfunction

  function automatic logic add_ovf(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                   input logic [DATA_W-1:0] s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  function automatic logic sub_ovf(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                   input logic [DATA_W-1:0] d);
    return (a[DATA_W-1] != b[DATA_W-1]) && (d[DATA_W-1] != a[DATA_W-1]);
  endfunction

  assign accept = rst_n && (state == IDLE) && start_i;

  // Only the four real shift codes get a nonzero iteration count.
  always_comb begin
    cnt_load = '0;
    if (FURslt_i == 2'b01) begin
      if (ALU_operation_i[3:1] == 3'b000)      cnt_load = shamt_i;
      else if (ALU_operation_i[3:1] == 3'b001) cnt_load = src1_i[4:0];
    end
  end

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    case (fur_q)
      2'b00: begin
        res_d = alu_result(op_q, a_q, b_q);
        if (op_q == 4'b0010)      ovf_d = add_ovf(a_q, b_q, res_d);
        else if (op_q == 4'b0110) ovf_d = sub_ovf(a_q, b_q, res_d);
      end
      2'b01:   res_d = (op_q[3:2] == 2'b00) ? sh_q : '0;
      2'b10:   res_d = {b_q[15:0], {(DATA_W-16){1'b0}}};
      default: res_d = '0;
    endcase
  end

  // Operand capture: no reset needed, only read after an accept.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q  <= ALU_operation_i;
      fur_q <= FURslt_i;
      a_q   <= src1_i;
      b_q   <= src2_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b1;
      overflow_o <= 1'b0;
      cnt_q      <= '0;
      sh_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state  <= RUN;
            busy_o <= 1'b1;
            cnt_q  <= cnt_load;
            sh_q   <= src2_i;
          end
        end
        RUN: begin
          if (cnt_q != '0) begin
            sh_q  <= op_q[0] ? (sh_q >> 1) : (sh_q << 1);
            cnt_q <= cnt_q - 5'd1;
          end else begin
            result_o   <= res_d;
            zero_o     <= (res_d == '0);
            overflow_o <= ovf_d;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_exec_unit.sv
// Directed bench for iter_exec_unit: ALU ops, iterative shifts, handshake and mid-shift reset.
module tb_iter_exec_unit;
  localparam int DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_n;
  logic              start_i;
  logic [3:0]        ALU_operation_i;
  logic [1:0]        FURslt_i;
  logic [DATA_W-1:0] src1_i;
  logic [DATA_W-1:0] src2_i;
  logic [4:0]        shamt_i;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] result_o;
  logic              zero_o;
  logic              overflow_o;

  int n_cmp = 0;
  int n_bad = 0;

  iter_exec_unit #(.DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i),
    .ALU_operation_i(ALU_operation_i), .FURslt_i(FURslt_i),
    .src1_i(src1_i), .src2_i(src2_i), .shamt_i(shamt_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .zero_o(zero_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one operation, measure edges from accept to done and cycles with busy high.
  // lat = -1 if done never arrives. Returns with the DUT back in IDLE.
  task automatic run_op(input logic [1:0] fur, input logic [3:0] op,
                        input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] sh,
                        output int lat, output int busy_cnt);
    @(negedge clk_i);
    FURslt_i = fur; ALU_operation_i = op; src1_i = s1; src2_i = s2; shamt_i = sh;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    busy_cnt = busy_o ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk_i); #1;
      if (busy_o) busy_cnt++;
      if (done_o) begin lat = k; break; end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_i = 1'b0; ALU_operation_i = '0; FURslt_i = '0;
    src1_i = '0; src2_i = '0; shamt_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_o); end
    n_cmp++; if (result_o !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result_o); end
    n_cmp++; if (zero_o !== 1'b1) begin n_bad++; $display("FAIL reset_zero: got %b want 1", zero_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
    @(negedge clk_i); rst_n = 1'b1;
  endtask

  task automatic test_add;
    int lat, bc;
    run_op(2'b00, 4'b0010, 32'd7, 32'd5, 5'd0, lat, bc);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL add_latency: got %0d want 1", lat); end
    n_cmp++; if (result_o !== 32'd12) begin n_bad++; $display("FAIL add_result: got %h want 0000000c", result_o); end
    n_cmp++; if (zero_o !== 1'b0) begin n_bad++; $display("FAIL add_zero: got %b want 0", zero_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_bad++; $display("FAIL add_ovf: got %b want 0", overflow_o); end
    run_op(2'b00, 4'b0010, 32'h7FFFFFFF, 32'd1, 5'd0, lat, bc);
    n_cmp++; if (result_o !== 32'h80000000) begin n_bad++; $display("FAIL addovf_result: got %h want 80000000", result_o); end
    n_cmp++; if (overflow_o !== 1'b1) begin n_bad++; $display("FAIL addovf_ovf: got %b want 1", overflow_o); end
  endtask

  task automatic test_alu_misc;
    int lat, bc;
    run_op(2'b00, 4'b0110, 32'h80000000, 32'd1, 5'd0, lat, bc);
    n_cmp++; if (result_o !== 32'h7FFFFFFF) begin n_bad++; $display("FAIL sub_result: got %h want 7fffffff", result_o); end
    n_cmp++; if (overflow_o !== 1'b1) begin n_bad++; $display("FAIL sub_ovf: got %b want 1", overflow_o); end
    run_op(2'b00, 4'b0111, 32'hFFFFFFFF, 32'd1, 5'd0, lat, bc);
    n_cmp++; if (result_o !== 32'd1) begin n_bad++; $display("FAIL slt_result: got %h want 00000001", result_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_bad++; $display("FAIL slt_ovf: got %b want 0", overflow_o); end
    run_op(2'b00, 4'b1000, 32'd5, 32'd5, 5'd0, lat, bc);
    n_cmp++; if (result_o !== 32'd0) begin n_bad++; $display("FAIL bcmp_result: got %h want 0", result_o); end
    n_cmp++; if (zero_o !== 1'b1) begin n_bad++; $display("FAIL bcmp_zero: got %b want 1", zero_o); end
    run_op(2'b00, 4'b0000, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0, lat, bc);
    n_cmp++; if (result_o !== 32'h00F0F000) begin n_bad++; $display("FAIL and_result: got %h want 00f0f000", result_o); end
    run_op(2'b00, 4'b0001, 32'hF0000000, 32'h0000000F, 5'd0, lat, bc);
    n_cmp++; if (result_o !== 32'hF000000F) begin n_bad++; $display("FAIL or_result: got %h want f000000f", result_o); end
    run_op(2'b00, 4'b1100, 32'hF0000000, 32'h0000000F, 5'd0, lat, bc);
    n_cmp++; if (result_o !== 32'h0FFFFFF0) begin n_bad++; $display("FAIL nor_result: got %h want 0ffffff0", result_o); end
    run_op(2'b11, 4'b0010, 32'd9, 32'd9, 5'd0, lat, bc);
    n_cmp++; if (result_o !== 32'd0) begin n_bad++; $display("FAIL fur11_result: got %h want 0", result_o); end
  endtask

  task automatic test_shift;
    int lat, bc;
    run_op(2'b01, 4'b0000, 32'd0, 32'h0000000F, 5'd4, lat, bc);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL sll_latency: got %0d want 5", lat); end
    n_cmp++; if (bc !== 5) begin n_bad++; $display("FAIL sll_busy_cycles: got %0d want 5", bc); end
    n_cmp++; if (result_o !== 32'h000000F0) begin n_bad++; $display("FAIL sll_result: got %h want 000000f0", result_o); end
    run_op(2'b01, 4'b0011, 32'd31, 32'h80000000, 5'd0, lat, bc);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL srlv_latency: got %0d want 32", lat); end
    n_cmp++; if (result_o !== 32'd1) begin n_bad++; $display("FAIL srlv_result: got %h want 00000001", result_o); end
    run_op(2'b01, 4'b0001, 32'd0, 32'hF0000000, 5'd8, lat, bc);
    n_cmp++; if (result_o !== 32'h00F00000) begin n_bad++; $display("FAIL srl_result: got %h want 00f00000", result_o); end
    run_op(2'b01, 4'b0010, 32'hFFFFFFE3, 32'h00000003, 5'd0, lat, bc);
    n_cmp++; if (result_o !== 32'h00000018) begin n_bad++; $display("FAIL sllv_result: got %h want 00000018", result_o); end
    run_op(2'b01, 4'b0000, 32'd0, 32'hDEADBEEF, 5'd0, lat, bc);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL sll0_latency: got %0d want 1", lat); end
    n_cmp++; if (result_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sll0_result: got %h want deadbeef", result_o); end
    run_op(2'b01, 4'b0100, 32'd3, 32'hDEADBEEF, 5'd7, lat, bc);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL badshift_latency: got %0d want 1", lat); end
    n_cmp++; if (result_o !== 32'd0) begin n_bad++; $display("FAIL badshift_result: got %h want 0", result_o); end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk_i);
    FURslt_i = 2'b01; ALU_operation_i = 4'b0000; src1_i = 32'd0; src2_i = 32'd1; shamt_i = 5'd3;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    FURslt_i = 2'b10; ALU_operation_i = 4'b0001; src1_i = 32'hFFFFFFFF; src2_i = 32'h00001234; shamt_i = 5'd9;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_i); #1;
      if (done_o) begin lat = k; break; end
    end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 4", lat); end
    n_cmp++; if (result_o !== 32'h00000008) begin n_bad++; $display("FAIL b2b_first_result: got %h want 00000008", result_o); end
    @(posedge clk_i); #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL b2b_no_accept_in_done: busy got %b want 0", busy_o); end
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_in_idle: busy got %b want 1", busy_o); end
    n_cmp++; if (result_o !== 32'h00000008) begin n_bad++; $display("FAIL b2b_result_hold: got %h want 00000008", result_o); end
    @(posedge clk_i); #1;
    n_cmp++; if (done_o !== 1'b1) begin n_bad++; $display("FAIL lui_done: got %b want 1", done_o); end
    n_cmp++; if (result_o !== 32'h12340000) begin n_bad++; $display("FAIL lui_result: got %h want 12340000", result_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid;
    int lat, bc, seen_done;
    @(negedge clk_i);
    FURslt_i = 2'b01; ALU_operation_i = 4'b0001; src1_i = 32'd0; src2_i = 32'hFFFFFFFF; shamt_i = 5'd20;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    @(negedge clk_i); rst_n = 1'b0;
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy_o); end
    n_cmp++; if (result_o !== 32'h0) begin n_bad++; $display("FAIL midrst_result: got %h want 0", result_o); end
    n_cmp++; if (zero_o !== 1'b1) begin n_bad++; $display("FAIL midrst_zero: got %b want 1", zero_o); end
    seen_done = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk_i); #1;
      if (done_o) seen_done = 1;
    end
    n_cmp++; if (seen_done !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d want 0", seen_done); end
    run_op(2'b00, 4'b0010, 32'd2, 32'd3, 5'd0, lat, bc);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL postrst_add_latency: got %0d want 1", lat); end
    n_cmp++; if (result_o !== 32'd5) begin n_bad++; $display("FAIL postrst_add_result: got %h want 00000005", result_o); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_misc();
    test_shift();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
